// File: rtl/bird_pkg.sv
// Shared types and default geometry for the flappy-bird controller.
// Imported by bird_controller and flap_debounce.
package bird_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FLY  = 2'd1,
    ST_DEAD = 2'd2
  } state_e;

  localparam int VEL_W = 8;
  localparam int POS_W = 12;
  typedef logic signed [VEL_W-1:0] vel_t;

  localparam int DEF_BIRD_X      = 200;
  localparam int DEF_BIRD_W      = 16;
  localparam int DEF_BIRD_H      = 12;
  localparam int DEF_START_Y     = 220;
  localparam int DEF_GROUND_Y    = 440;
  localparam int DEF_GRAVITY     = 1;
  localparam int DEF_FLAP_V      = 8;
  localparam int DEF_VMAX        = 10;
  localparam int DEF_DEAD_FRAMES = 60;

  // 20 ms at 50 MHz
  localparam int DEB_STABLE = 1_000_000;

  function automatic logic in_span(input logic [10:0] v, input logic [10:0] lo,
                                   input logic [10:0] len);
    return (v >= lo) && (v < lo + len);
  endfunction

endpackage

// File: rtl/bird_if.sv
// Scan-side bundle between vga_timing / colour mux and bird_controller.
// master = video side, slave = bird_controller.
interface bird_if;
  logic       i_vs;
  logic [9:0] i_x;
  logic [9:0] i_y;
  logic       o_bird_px;

  modport master (output i_vs, i_x, i_y, input o_bird_px);
  modport slave  (input i_vs, i_x, i_y, output o_bird_px);
endinterface

// File: rtl/flap_debounce.sv
// Flap button conditioner: 2-flop synchroniser plus 20-bit stability counter.
// Only instantiated when BIRD_DEBOUNCE_EN is defined.
module flap_debounce
  import bird_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_level
);

  logic        sync1_q, sync2_q;
  logic        level_q, level_d;
  logic [19:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == 20'(DEB_STABLE - 1)) level_d = sync2_q;
      else                              cnt_d   = cnt_q + 20'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_level = level_q;

endmodule

// File: rtl/bird_controller.sv
// Per-frame bird physics, game FSM and registered bird-pixel flag.
// Define BIRD_DEBOUNCE_EN to route i_flap through flap_debounce.
//
// state   | meaning
// IDLE    | bird parked at START_Y, waiting for a flap
// FLY     | physics runs on every frame tick
// DEAD    | bird frozen; counts DEAD_FRAMES ticks before a flap may restart
module bird_controller
  import bird_pkg::*;
#(
  parameter int BIRD_X      = DEF_BIRD_X,
  parameter int BIRD_W      = DEF_BIRD_W,
  parameter int BIRD_H      = DEF_BIRD_H,
  parameter int START_Y     = DEF_START_Y,
  parameter int GROUND_Y    = DEF_GROUND_Y,
  parameter int GRAVITY     = DEF_GRAVITY,
  parameter int FLAP_V      = DEF_FLAP_V,
  parameter int VMAX        = DEF_VMAX,
  parameter int DEAD_FRAMES = DEF_DEAD_FRAMES
) (
  input  logic       clk,
  input  logic       rst_n,
  bird_if.slave      vga,
  input  logic       i_flap,
  input  logic       i_hit,
  output logic [9:0] o_bird_y,
  output logic [1:0] o_state
);

  localparam int DCW = $clog2(DEAD_FRAMES + 1);

  state_e           state_q, state_d;
  logic [9:0]       y_q, y_d;
  vel_t             vel_q, vel_d;
  logic [DCW-1:0]   dead_q, dead_d;
  logic             latch_q, latch_d;
  logic             px_q, px_d;
  logic             vs_q, flap_q;
  logic             flap_lvl, tick, flap_rise, latch_eff;

  vel_t                    vel_grav, fly_vel, fly_v;
  logic signed [POS_W-1:0] y_nx;
  logic [9:0]              fly_y;
  logic                    fly_dead;

`ifdef BIRD_DEBOUNCE_EN
  flap_debounce u_flap_debounce (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_btn   (i_flap),
    .o_level (flap_lvl)
  );
`else
  assign flap_lvl = i_flap;
`endif

  assign tick      = vga.i_vs & ~vs_q;
  assign flap_rise = flap_lvl & ~flap_q;
  // A flap arriving on the tick cycle is consumed by that tick
  assign latch_eff = latch_q | flap_rise;

  always_comb begin
    vel_grav = (vel_q >= vel_t'(VMAX - GRAVITY)) ? vel_t'(VMAX) : vel_q + vel_t'(GRAVITY);
    fly_vel  = latch_eff ? vel_t'(-FLAP_V) : vel_grav;
    y_nx     = $signed({2'b00, y_q}) + POS_W'(fly_vel);
    fly_y    = y_nx[9:0];
    fly_v    = fly_vel;
    fly_dead = 1'b0;
    if (y_nx[POS_W-1]) begin
      fly_y = '0;
      fly_v = '0;
    end else if (y_nx >= POS_W'(GROUND_Y - BIRD_H)) begin
      fly_y    = 10'(GROUND_Y - BIRD_H);
      fly_v    = '0;
      fly_dead = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    vel_d   = vel_q;
    dead_d  = dead_q;
    latch_d = latch_eff;
    case (state_q)
      ST_IDLE: begin
        y_d    = 10'(START_Y);
        vel_d  = '0;
        dead_d = '0;
        if (tick) begin
          latch_d = 1'b0;
          if (latch_eff) begin
            state_d = fly_dead ? ST_DEAD : ST_FLY;
            y_d     = fly_y;
            vel_d   = fly_v;
          end
        end
      end
      ST_FLY: begin
        if (i_hit) begin
          state_d = ST_DEAD;
          dead_d  = '0;
          latch_d = 1'b0;
        end else if (tick) begin
          latch_d = 1'b0;
          y_d     = fly_y;
          vel_d   = fly_v;
          if (fly_dead) begin
            state_d = ST_DEAD;
            dead_d  = '0;
          end
        end
      end
      ST_DEAD: begin
        if (dead_q != DCW'(DEAD_FRAMES)) begin
          latch_d = 1'b0;
          if (tick) dead_d = dead_q + DCW'(1);
        end else if (tick) begin
          latch_d = 1'b0;
          if (latch_eff) begin
            state_d = ST_IDLE;
            y_d     = 10'(START_Y);
            vel_d   = '0;
            dead_d  = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Compares against the y currently on screen, not the one being computed
  always_comb begin
    px_d = in_span({1'b0, vga.i_x}, 11'(BIRD_X), 11'(BIRD_W)) &&
           in_span({1'b0, vga.i_y}, {1'b0, y_q}, 11'(BIRD_H));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      y_q     <= 10'(START_Y);
      vel_q   <= '0;
      dead_q  <= '0;
      latch_q <= 1'b0;
      px_q    <= 1'b0;
      vs_q    <= 1'b1;
      flap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      vel_q   <= vel_d;
      dead_q  <= dead_d;
      latch_q <= latch_d;
      px_q    <= px_d;
      vs_q    <= vga.i_vs;
      flap_q  <= flap_lvl;
    end
  end

  assign vga.o_bird_px = px_q;
  assign o_bird_y      = y_q;
  assign o_state       = state_q;

endmodule

// File: tb/tb_bird_controller.sv
// Scoreboard bench for bird_controller: driver queues expectations, monitor checks at negedge.
module tb_bird_controller;
  import bird_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_flap = 1'b0;
  logic       i_hit = 1'b0;
  logic [9:0] o_bird_y;
  logic [1:0] o_state;

  bird_if vga();

  bird_controller dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .vga      (vga),
    .i_flap   (i_flap),
    .i_hit    (i_hit),
    .o_bird_y (o_bird_y),
    .o_state  (o_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int    due;
    int    kind;   // 0 state, 1 y, 2 pixel
    string name;
    int    exp;
  } chk_t;

  chk_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int m_state, m_y, m_vel, m_dead;

  task automatic push(input int kind, input string name, input int e, input int lat);
    chk_t c;
    c.due  = cyc + lat;
    c.kind = kind;
    c.name = name;
    c.exp  = e;
    exp_q.push_back(c);
  endtask

  task automatic m_reset();
    m_state = 0; m_y = 220; m_vel = 0; m_dead = 0;
  endtask

  task automatic m_fly(input bit flap);
    int v, ny;
    v  = flap ? -8 : ((m_vel + 1 > 10) ? 10 : m_vel + 1);
    ny = m_y + v;
    if (ny < 0) begin
      m_y = 0; m_vel = 0;
    end else if (ny + 12 >= 440) begin
      m_y = 428; m_vel = 0; m_state = 2; m_dead = 0;
    end else begin
      m_y = ny; m_vel = v;
    end
  endtask

  task automatic m_tick(input bit flap, input bit hit);
    case (m_state)
      0: if (flap) begin m_state = 1; m_fly(1'b1); end
      1: if (hit) begin m_state = 2; m_dead = 0; end
         else m_fly(flap);
      default: begin
        if (m_dead == 60) begin
          if (flap) m_reset();
        end else m_dead++;
      end
    endcase
  endtask

  // One frame: vsync low, optional flap (before or on the tick cycle), rising vsync = tick
  task automatic tick(input bit flap, input bit hit = 0, input bit same = 0,
                      input int lit_st = -1, input int lit_y = -1);
    @(posedge clk); #1 vga.i_vs = 1'b0; i_flap = flap & ~same;
    @(posedge clk); #1 i_flap = 1'b0;
    @(posedge clk); #1 vga.i_vs = 1'b1; i_hit = hit; i_flap = flap & same;
    m_tick(flap, hit);
    push(0, "state", m_state, 1);
    push(1, "bird_y", m_y, 1);
    if (lit_st >= 0) push(0, "state_lit", lit_st, 1);
    if (lit_y >= 0)  push(1, "bird_y_lit", lit_y, 1);
    @(posedge clk); #1 i_hit = 1'b0; i_flap = 1'b0;
  endtask

  task automatic pix(input int x, input int y, input int e);
    @(posedge clk); #1 vga.i_x = 10'(x); vga.i_y = 10'(y);
    push(2, "bird_px", e, 1);
  endtask

  initial begin : monitor
    chk_t c;
    int   act;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        c = exp_q.pop_front();
        case (c.kind)
          0:       act = int'(o_state);
          1:       act = int'(o_bird_y);
          default: act = int'(vga.o_bird_px);
        endcase
        n_cmp++;
        if (c.due != cyc) begin
          n_bad++;
          $display("FAIL %s: check missed its cycle (due %0d, now %0d)", c.name, c.due, cyc);
        end else if (act != c.exp) begin
          n_bad++;
          $display("FAIL %s: got %0d expected %0d (cycle %0d)", c.name, act, c.exp, cyc);
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int guard;
    vga.i_vs = 1'b1; vga.i_x = '0; vga.i_y = '0;
    m_reset();

    @(posedge clk); #1;
    push(0, "reset_state", 0, 0);
    push(1, "reset_y", 220, 0);
    push(2, "reset_px", 0, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    pix(0, 0, 0);

    for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 220);

    pix(200, 220, 1);
    pix(215, 231, 1);
    pix(216, 220, 0);
    pix(199, 225, 0);
    pix(200, 232, 0);
    pix(200, 219, 0);

    // hit in IDLE is ignored
    tick(0, 1, 0, 0, 220);

    tick(1, 0, 0, 1, 212);
    tick(0, 0, 0, 1, 205);
    tick(0, 0, 0, 1, 199);

    guard = 0;
    while (m_state == 1 && guard < 100) begin tick(0); guard++; end
    tick(0, 0, 0, 2, 428);
    guard = 0;
    while (m_dead < 60 && guard < 100) begin tick(0); guard++; end
    tick(1, 0, 0, 0, 220);

    // Hit coincident with a tick freezes y
    tick(1, 0, 0, 1, 212);
    tick(0, 0, 0, 1, 205);
    tick(0, 1, 0, 2, 205);
    guard = 0;
    while (m_dead < 30 && guard < 100) begin tick(0); guard++; end
    tick(1, 0, 0, 2, 205);
    guard = 0;
    while (m_dead < 60 && guard < 100) begin tick(0); guard++; end
    tick(1, 0, 1, 0, 220);

    // Ceiling: flap every frame until clamped, then one free frame
    tick(1, 0, 0, 1, 212);
    guard = 0;
    while (m_y != 0 && guard < 40) begin tick(1, 0, guard[0]); guard++; end
    tick(0, 0, 0, 1, 1);

    // Asynchronous reset in FLY
    @(posedge clk); #1 rst_n = 1'b0;
    m_reset();
    push(0, "midreset_state", 0, 0);
    push(1, "midreset_y", 220, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick(0, 0, 0, 0, 220);

    // Hit on a non-tick cycle
    tick(1, 0, 0, 1, 212);
    @(posedge clk); #1 i_hit = 1'b1;
    m_state = 2; m_dead = 0;
    push(0, "hit_state", 2, 1);
    push(1, "hit_y", 212, 1);
    @(posedge clk); #1 i_hit = 1'b0;

    repeat (4) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_bad += exp_q.size();
      $display("FAIL pending: got %0d unchecked expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
